instr_encoder_loader: RTL and testbench

- Inverse of the instruction decoder: accepts decoded RV32I fields (major opcode, register indices, funct3, alt bit, full 32-bit immediate) over a valid/ready handshake.
- Packs the fields into the 32-bit instruction word and writes it into instruction memory at consecutive word addresses.
- Used by the test/boot path to load programs without a pre-assembled image.
- Flags unencodable immediates and unknown opcodes.

---
 rtl/instr_encoder_loader.sv | 149 ++++++++++++++
 tb/tb_instr_encoder_loader.sv | 485 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
// rtl/instr_encoder_loader.sv - packs decoded RV32I fields into instruction words and streams them into instruction memory
module instr_encoder_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 256
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     finish,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4:0]               in_opcode,
    input  logic [4:0]               in_rd,
    input  logic [4:0]               in_rs1,
    input  logic [4:0]               in_rs2,
    input  logic [2:0]               in_funct3,
    input  logic                     in_alt,
    input  logic [31:0]              in_imm,
    output logic                     imem_we,
    output logic [31:0]              imem_addr,
    output logic [31:0]              imem_wdata,
    input  logic                     imem_ready,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

    state_t        state;
    logic [CW-1:0] accepted;
    logic [31:0]   enc_word;
    logic          enc_bad;
    logic [6:0]    op7;
    logic          fits_i;
    logic          fits_b;
    logic          fits_j;
    logic          accept;
    logic          wr_done;

    assign op7    = {in_opcode, 2'b11};
    assign fits_i = in_imm[31:11] == {21{in_imm[31]}};
    assign fits_b = in_imm[31:12] == {20{in_imm[31]}};
    assign fits_j = in_imm[31:20] == {12{in_imm[31]}};

    // Unknown opcodes fall through to a NOP and are flagged.
    always_comb begin
        enc_word = 32'h0000_0013;
        enc_bad  = 1'b1;
        case (in_opcode)
            5'b01100: begin
                enc_word = {1'b0, in_alt, 5'b0, in_rs2, in_rs1, in_funct3, in_rd, op7};
                enc_bad  = 1'b0;
            end
            5'b00100, 5'b00000, 5'b11001: begin
                if (in_opcode == 5'b00100 && in_funct3[1:0] == 2'b01) begin
                    enc_word = {1'b0, in_alt, 5'b0, in_imm[4:0], in_rs1, in_funct3, in_rd, op7};
                    enc_bad  = |in_imm[31:5];
                end else begin
                    enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, op7};
                    enc_bad  = !fits_i;
                end
            end
            5'b01000: begin
                enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], op7};
                enc_bad  = !fits_i;
            end
            5'b11000: begin
                enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:1], in_imm[11], op7};
                enc_bad  = !fits_b || in_imm[0];
            end
            5'b01101, 5'b00101: begin
                enc_word = {in_imm[31:12], in_rd, op7};
                enc_bad  = |in_imm[11:0];
            end
            5'b11011: begin
                enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, op7};
                enc_bad  = !fits_j || in_imm[0];
            end
            default: begin
                enc_word = 32'h0000_0013;
                enc_bad  = 1'b1;
            end
        endcase
    end

    // The single output register may be refilled on the same edge it drains.
    assign in_ready = (state == LOAD) && (accepted < CW'(DEPTH)) && (!imem_we || imem_ready);
    assign accept   = in_valid && in_ready;
    assign wr_done  = imem_we && imem_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            imem_we    <= 1'b0;
            imem_addr  <= BASE_ADDR;
            imem_wdata <= 32'h0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            count      <= '0;
            accepted   <= '0;
        end else begin
            if (wr_done) begin
                imem_addr <= imem_addr + 32'd4;
                count     <= count + 1'b1;
            end
            if (accept) begin
                imem_we    <= 1'b1;
                imem_wdata <= enc_word;
                accepted   <= accepted + 1'b1;
                if (enc_bad) begin
                    err <= 1'b1;
                end
            end else if (wr_done) begin
                imem_we <= 1'b0;
            end
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= LOAD;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        err       <= 1'b0;
                        count     <= '0;
                        accepted  <= '0;
                        imem_addr <= BASE_ADDR;
                    end
                end
                LOAD: begin
                    if (finish || (accept && accepted == CW'(DEPTH - 1))) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!imem_we || imem_ready) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb/tb_instr_encoder_loader.sv - bench for instr_encoder_loader against a field-arithmetic reference encoder
module tb_instr_encoder_loader;
    localparam int DEPTH = 4;

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic                   start;
    logic                   finish;
    logic                   in_valid;
    logic                   in_ready;
    logic [4:0]             in_opcode;
    logic [4:0]             in_rd;
    logic [4:0]             in_rs1;
    logic [4:0]             in_rs2;
    logic [2:0]             in_funct3;
    logic                   in_alt;
    logic [31:0]            in_imm;
    logic                   imem_we;
    logic [31:0]            imem_addr;
    logic [31:0]            imem_wdata;
    logic                   imem_ready;
    logic                   busy;
    logic                   done;
    logic                   err;
    logic [$clog2(DEPTH):0] count;

    typedef struct packed {
        logic [4:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic        alt;
        logic [31:0] imm;
    } bundle_t;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          ready_mode = 2;
    bundle_t     sess[$];
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_cyc[$];

    instr_encoder_loader #(.BASE_ADDR(32'h0000_0000), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .finish(finish),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
        .in_alt(in_alt), .in_imm(in_imm), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .imem_ready(imem_ready), .busy(busy), .done(done),
        .err(err), .count(count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset_n && imem_we && imem_ready) begin
            wr_addr.push_back(imem_addr);
            wr_data.push_back(imem_wdata);
            wr_cyc.push_back(cyc);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 0) imem_ready = 1'b1;
            else if (ready_mode == 1) imem_ready = 1'($urandom_range(0, 1));
        end
    end

    function automatic bundle_t mk(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                   input logic [4:0] rs2, input logic [2:0] f3, input logic alt,
                                   input logic [31:0] imm);
        bundle_t b;
        b.op = op; b.rd = rd; b.rs1 = rs1; b.rs2 = rs2; b.f3 = f3; b.alt = alt; b.imm = imm;
        return b;
    endfunction

    // Instruction layout rebuilt from field positions and value ranges.
    function automatic logic [31:0] ref_word(input bundle_t b, output bit bad);
        int signed   s;
        logic [31:0] im, op7, rd, rs1, rs2, f3, alt, w;
        s   = $signed(b.imm);
        im  = b.imm;
        op7 = {25'd0, b.op, 2'b11};
        rd  = 32'(b.rd) << 7;
        rs1 = 32'(b.rs1) << 15;
        rs2 = 32'(b.rs2) << 20;
        f3  = 32'(b.f3) << 12;
        alt = 32'(b.alt) << 30;
        bad = 1'b0;
        case (b.op)
            5'b01100: w = alt | rs2 | rs1 | f3 | rd | op7;
            5'b00100, 5'b00000, 5'b11001: begin
                if (b.op == 5'b00100 && (b.f3 == 3'd1 || b.f3 == 3'd5)) begin
                    w   = alt | ((im % 32'd32) << 20) | rs1 | f3 | rd | op7;
                    bad = im > 32'd31;
                end else begin
                    w   = ((im % 32'd4096) << 20) | rs1 | f3 | rd | op7;
                    bad = s < -2048 || s > 2047;
                end
            end
            5'b01000: begin
                w   = (((im / 32'd32) % 32'd128) << 25) | rs2 | rs1 | f3 | ((im % 32'd32) << 7) | op7;
                bad = s < -2048 || s > 2047;
            end
            5'b11000: begin
                w = (((im >> 12) & 32'd1) << 31) | (((im >> 5) % 32'd64) << 25) | rs2 | rs1 | f3
                    | (((im >> 1) % 32'd16) << 8) | (((im >> 11) & 32'd1) << 7) | op7;
                bad = s < -4096 || s > 4095 || (im % 32'd2) != 0;
            end
            5'b01101, 5'b00101: begin
                w   = (im - (im % 32'd4096)) | rd | op7;
                bad = (im % 32'd4096) != 0;
            end
            5'b11011: begin
                w = (((im >> 20) & 32'd1) << 31) | (((im >> 1) % 32'd1024) << 21)
                    | (((im >> 11) & 32'd1) << 20) | (((im >> 12) % 32'd256) << 12) | rd | op7;
                bad = s < -(1 << 20) || s >= (1 << 20) || (im % 32'd2) != 0;
            end
            default: begin
                w   = 32'h0000_0013;
                bad = 1'b1;
            end
        endcase
        return w;
    endfunction

    function automatic bundle_t rnd_bundle();
        bundle_t     b;
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 9))
            0: b.op = 5'b01100;  1: b.op = 5'b00100;  2: b.op = 5'b00000;
            3: b.op = 5'b11001;  4: b.op = 5'b01000;  5: b.op = 5'b11000;
            6: b.op = 5'b01101;  7: b.op = 5'b00101;  8: b.op = 5'b11011;
            default: b.op = 5'($urandom);
        endcase
        b.rd = 5'($urandom); b.rs1 = 5'($urandom); b.rs2 = 5'($urandom);
        b.f3 = 3'($urandom); b.alt = 1'($urandom);
        case ($urandom_range(0, 5))
            0: b.imm = r;
            1: b.imm = {{20{r[11]}}, r[11:0]};
            2: b.imm = {{19{r[12]}}, r[12:1], 1'b0};
            3: b.imm = {r[31:12], 12'h0};
            4: b.imm = {27'h0, r[4:0]};
            default: b.imm = {{11{r[20]}}, r[20:1], 1'b0};
        endcase
        return b;
    endfunction

    function automatic logic [31:0] wd(input int i);
        return (i < wr_data.size()) ? wr_data[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] wa(input int i);
        return (i < wr_addr.size()) ? wr_addr[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic set_fields(input bundle_t b);
        in_opcode = b.op; in_rd = b.rd; in_rs1 = b.rs1; in_rs2 = b.rs2;
        in_funct3 = b.f3; in_alt = b.alt; in_imm = b.imm;
    endtask

    task automatic push(input bundle_t b, input int budget, output bit acc);
        set_fields(b);
        in_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < budget && !acc; i++) begin
            @(negedge clk);
            if (in_ready) acc = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic pulse_finish();
        finish = 1'b1;
        @(posedge clk);
        #1;
        finish = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(posedge clk);
            #1;
            ok = done;
        end
    endtask

    task automatic clear_writes();
        wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
    endtask

    task automatic run_session(input int mode, input string name);
        bit          acc, ok, bad, exp_err;
        int          n_exp;
        logic [31:0] w;
        ready_mode = mode;
        clear_writes();
        pulse_start();
        foreach (sess[i]) begin
            push(sess[i], (i < DEPTH) ? 200 : 10, acc);
            checks++;
            if (acc !== (i < DEPTH)) begin
                failures++;
                $display("FAIL %s accept[%0d] got %0b want %0b", name, i, acc, i < DEPTH);
            end
        end
        pulse_finish();
        wait_done(ok);
        checks++;
        if (ok !== 1'b1) begin failures++; $display("FAIL %s done_timeout got %0b want 1", name, ok); end
        n_exp = (sess.size() < DEPTH) ? sess.size() : DEPTH;
        exp_err = 1'b0;
        checks++;
        if (wr_data.size() !== n_exp) begin
            failures++; $display("FAIL %s nwrites got %0d want %0d", name, wr_data.size(), n_exp);
        end
        for (int i = 0; i < n_exp; i++) begin
            w = ref_word(sess[i], bad);
            exp_err |= bad;
            checks++;
            if (wd(i) !== w) begin failures++; $display("FAIL %s word[%0d] got %h want %h", name, i, wd(i), w); end
            checks++;
            if (wa(i) !== 32'(4 * i)) begin
                failures++; $display("FAIL %s addr[%0d] got %h want %h", name, i, wa(i), 32'(4 * i));
            end
        end
        checks++;
        if (err !== exp_err) begin failures++; $display("FAIL %s err got %0b want %0b", name, err, exp_err); end
        checks++;
        if (count !== 3'(n_exp)) begin failures++; $display("FAIL %s count got %0d want %0d", name, count, n_exp); end
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            failures++; $display("FAIL %s idle_after got busy=%0b in_ready=%0b want 0 0", name, busy, in_ready);
        end
        ready_mode = 0;
    endtask

    task automatic test_reset();
        checks++;
        if ({in_ready, imem_we, imem_addr, imem_wdata, busy, done, err, count} !== 71'h0) begin
            failures++;
            $display("FAIL reset_state got we=%0b addr=%h wdata=%h busy=%0b done=%0b err=%0b count=%0d want all 0",
                     imem_we, imem_addr, imem_wdata, busy, done, err, count);
        end
        reset_n = 1'b1;
        ready_mode = 0;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL idle_no_ready got in_ready=%0b busy=%0b want 0 0", in_ready, busy);
        end
    endtask

    task automatic test_directed();
        bit acc, ok;
        clear_writes();
        pulse_start();
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL load_busy got %0b want 1", busy); end
        push(mk(5'b00100, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5), 20, acc);
        repeat (2) begin @(posedge clk); #1; end
        checks++;
        if (count !== 3'd1) begin failures++; $display("FAIL addi_count got %0d want 1", count); end
        checks++;
        if (wd(0) !== 32'h0050_0093 || wa(0) !== 32'h0) begin
            failures++; $display("FAIL addi_word got %h@%h want 00500093@0", wd(0), wa(0));
        end
        push(mk(5'b01100, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0), 20, acc);
        push(mk(5'b01100, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 32'd0), 20, acc);
        push(mk(5'b01000, 5'd0, 5'd1, 5'd2, 3'd2, 1'b0, 32'd8), 20, acc);
        wait_done(ok);
        checks++;
        if (ok !== 1'b1 || count !== 3'd4) begin
            failures++; $display("FAIL depth_autodrain got done=%0b count=%0d want 1 4", ok, count);
        end
        checks++;
        if (wd(1) !== 32'h0020_81B3 || wa(1) !== 32'd4) begin
            failures++; $display("FAIL add_word got %h@%h want 002081b3@4", wd(1), wa(1));
        end
        checks++;
        if (wd(2) !== 32'h4020_81B3 || wa(2) !== 32'd8) begin
            failures++; $display("FAIL sub_word got %h@%h want 402081b3@8", wd(2), wa(2));
        end
        checks++;
        if (wd(3) !== 32'h0020_A423) begin failures++; $display("FAIL sw_word got %h want 0020a423", wd(3)); end
        checks++;
        if (wr_cyc.size() < 3 || wr_cyc[2] - wr_cyc[1] !== 1) begin
            failures++; $display("FAIL back_to_back got nwrites=%0d want consecutive cycles", wr_cyc.size());
        end
    endtask

    task automatic test_session_b();
        sess.delete();
        sess.push_back(mk(5'b11000, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'hFFFF_FFFC));
        sess.push_back(mk(5'b11011, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd8));
        sess.push_back(mk(5'b01101, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'h1234_5000));
        run_session(0, "sess_b");
        checks++;
        if (wd(0) !== 32'hFE00_0EE3 || wd(1) !== 32'h0080_00EF || wd(2) !== 32'h1234_52B7) begin
            failures++; $display("FAIL b_j_u_words got %h %h %h want fe000ee3 008000ef 123452b7", wd(0), wd(1), wd(2));
        end
        checks++;
        if (err !== 1'b0) begin failures++; $display("FAIL b_j_u_err got %0b want 0", err); end
    endtask

    task automatic test_stall();
        bit          acc, ok, bad;
        bundle_t     b1, b2;
        logic [31:0] w1, w2;
        ready_mode = 2;
        imem_ready = 1'b0;
        clear_writes();
        pulse_start();
        b1 = mk(5'b00100, 5'd2, 5'd1, 5'd0, 3'd0, 1'b0, 32'd7);
        b2 = mk(5'b01100, 5'd4, 5'd2, 5'd3, 3'd0, 1'b1, 32'd0);
        w1 = ref_word(b1, bad);
        w2 = ref_word(b2, bad);
        push(b1, 20, acc);
        set_fields(b2);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (imem_we !== 1'b1 || imem_wdata !== w1 || imem_addr !== 32'h0 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold[%0d] got we=%0b wdata=%h addr=%h in_ready=%0b want 1 %h 0 0",
                         i, imem_we, imem_wdata, imem_addr, in_ready, w1);
            end
            @(posedge clk);
            #1;
        end
        imem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL stall_release_ready got %0b want 1", in_ready); end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        pulse_finish();
        wait_done(ok);
        checks++;
        if (wr_data.size() !== 2 || wd(0) !== w1 || wd(1) !== w2 || wa(1) !== 32'd4 || count !== 3'd2) begin
            failures++;
            $display("FAIL stall_resume got n=%0d %h %h addr1=%h count=%0d want 2 %h %h 4 2",
                     wr_data.size(), wd(0), wd(1), wa(1), count, w1, w2);
        end
        ready_mode = 0;
    endtask

    task automatic test_illegal();
        bit ok;
        sess.delete();
        sess.push_back(mk(5'b11000, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'd3));
        sess.push_back(mk(5'b11111, 5'd1, 5'd1, 5'd1, 3'd7, 1'b1, 32'd0));
        run_session(0, "illegal");
        checks++;
        if (err !== 1'b1 || wd(1) !== 32'h0000_0013) begin
            failures++; $display("FAIL illegal_flags got err=%0b word1=%h want 1 00000013", err, wd(1));
        end
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if (err !== 1'b1 || done !== 1'b1) begin
            failures++; $display("FAIL err_sticky got err=%0b done=%0b want 1 1", err, done);
        end
        pulse_start();
        checks++;
        if (err !== 1'b0 || done !== 1'b0 || count !== 3'd0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL restart_clear got err=%0b done=%0b count=%0d busy=%0b want 0 0 0 1", err, done, count, busy);
        end
        pulse_finish();
        wait_done(ok);
    endtask

    task automatic test_finish_accept();
        bit          ok, bad;
        bundle_t     b;
        logic [31:0] w;
        ready_mode = 0;
        clear_writes();
        pulse_start();
        b = mk(5'b00101, 5'd9, 5'd0, 5'd0, 3'd0, 1'b0, 32'hABCD_E000);
        w = ref_word(b, bad);
        set_fields(b);
        in_valid = 1'b1;
        finish = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL fin_acc_ready got %0b want 1", in_ready); end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        finish = 1'b0;
        wait_done(ok);
        checks++;
        if (ok !== 1'b1 || wr_data.size() !== 1 || wd(0) !== w || count !== 3'd1) begin
            failures++;
            $display("FAIL fin_acc_write got done=%0b n=%0d word=%h count=%0d want 1 1 %h 1",
                     ok, wr_data.size(), wd(0), count, w);
        end
    endtask

    task automatic test_depth();
        sess.delete();
        for (int i = 0; i < DEPTH + 1; i++) sess.push_back(rnd_bundle());
        run_session(1, "depth");
    endtask

    task automatic test_random();
        for (int s = 0; s < 6; s++) begin
            sess.delete();
            for (int i = 0; i < $urandom_range(1, DEPTH); i++) sess.push_back(rnd_bundle());
            run_session(1, "random");
        end
    endtask

    task automatic test_reset_mid();
        bit acc;
        ready_mode = 2;
        imem_ready = 1'b0;
        pulse_start();
        push(mk(5'b11000, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'd3), 20, acc);
        #2;
        checks++;
        if (imem_we !== 1'b1 || err !== 1'b1 || busy !== 1'b1) begin
            failures++; $display("FAIL pre_reset got we=%0b err=%0b busy=%0b want 1 1 1", imem_we, err, busy);
        end
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, imem_we, imem_addr, imem_wdata, busy, done, err, count} !== 71'h0) begin
            failures++;
            $display("FAIL async_reset got we=%0b addr=%h wdata=%h busy=%0b err=%0b count=%0d want all 0",
                     imem_we, imem_addr, imem_wdata, busy, err, count);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        ready_mode = 0;
        @(posedge clk);
        #1;
        checks++;
        if (imem_we !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            failures++; $display("FAIL post_reset_idle got we=%0b busy=%0b in_ready=%0b want 0 0 0", imem_we, busy, in_ready);
        end
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; finish = 1'b0; in_valid = 1'b0; imem_ready = 1'b0;
        in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_funct3 = '0; in_alt = 1'b0; in_imm = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_directed();
        test_session_b();
        test_stall();
        test_illegal();
        test_finish_accept();
        test_depth();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
